// File: rtl/pdm_pkg.sv
// Shared constants for the multi-channel PDM/PWM modulator.
// Mode encodings and default geometry.
package pdm_pkg;

  localparam logic PDM_MODE  = 1'b0;
  localparam logic PWM_MODE  = 1'b1;
  localparam int   DEF_NBITS = 11;
  localparam int   DEF_NCH   = 2;

endpackage

// File: rtl/pdm_channel.sv
// One modulator channel: active sample/mode, accumulator, output bit.
// Ports: clk, rst_n, en, load, sample_in, mode_in, cnt in; dout out.
module pdm_channel
  import pdm_pkg::*;
#(
  parameter int NBITS = DEF_NBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [NBITS-1:0] sample_in,
  input  logic             mode_in,
  input  logic [NBITS-1:0] cnt,
  output logic             dout
);

  logic [NBITS-1:0] sample;
  logic [NBITS-1:0] acc;
  logic [NBITS-1:0] acc_nxt;
  logic             mode;
  logic             dout_nxt;
  logic [NBITS:0]   sum;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, sample};
    acc_nxt  = acc;
    dout_nxt = 1'b0;
    if (mode == PDM_MODE) begin
      acc_nxt  = sum[NBITS-1:0];
      dout_nxt = sum[NBITS];
    end else begin
      dout_nxt = sample > cnt;
    end
    // a mode switch restarts the integrator
    if (load && (mode_in != mode))
      acc_nxt = '0;
    if (!en) begin
      acc_nxt  = '0;
      dout_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= '0;
      mode   <= PDM_MODE;
      acc    <= '0;
      dout   <= 1'b0;
    end else begin
      if (load) begin
        sample <= sample_in;
        mode   <= mode_in;
      end
      acc  <= acc_nxt;
      dout <= dout_nxt;
    end
  end

endmodule

// File: rtl/pdm_multi.sv
// Multi-channel PDM/PWM modulator with frame-aligned shadow update.
// Ports: clk, aresetn, din, mode, enable, din_valid in; din_ready, dout, frame out.
module pdm_multi
  import pdm_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int NCH   = DEF_NCH
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [NCH*NBITS-1:0] din,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH-1:0]       enable,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [NCH-1:0]       dout,
  output logic                 frame
);

  logic                 rst_meta;
  logic                 rst_n;
  logic [NBITS-1:0]     cnt;
  logic                 pending;
  logic [NCH*NBITS-1:0] shadow_din;
  logic [NCH-1:0]       shadow_mode;
  logic                 wrap;
  logic                 xfer;
  logic                 load;

  // assert asynchronously, release after two clk edges
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  assign wrap      = cnt == '1;
  assign din_ready = rst_n && !pending;
  assign xfer      = din_valid && din_ready;
  assign load      = wrap && pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      frame       <= 1'b0;
      pending     <= 1'b0;
      shadow_din  <= '0;
      shadow_mode <= '0;
    end else begin
      cnt   <= cnt + 1'b1;
      frame <= wrap;
      if (load)
        pending <= 1'b0;
      // xfer needs pending clear, so never overlaps load
      if (xfer) begin
        shadow_din  <= din;
        shadow_mode <= mode;
        pending     <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pdm_channel #(
      .NBITS(NBITS)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (enable[i]),
      .load     (load),
      .sample_in(shadow_din[i*NBITS +: NBITS]),
      .mode_in  (shadow_mode[i]),
      .cnt      (cnt),
      .dout     (dout[i])
    );
  end

endmodule

// File: tb/tb_pdm_multi.sv
// Directed bench for pdm_multi at NBITS=4, NCH=2.
// Frame-aligned 16-cycle captures against hand-computed bit patterns.
module tb_pdm_multi;

  logic       clk = 1'b0;
  logic       aresetn;
  logic [7:0] din;
  logic [1:0] mode;
  logic [1:0] enable;
  logic       din_valid;
  logic       din_ready;
  logic [1:0] dout;
  logic       frame;

  int checks = 0;
  int errors = 0;

  logic [15:0] v0, v1, fr, rdy;
  int n;

  pdm_multi #(
    .NBITS(4),
    .NCH  (2)
  ) dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .din      (din),
    .mode     (mode),
    .enable   (enable),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .dout     (dout),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // capture one frame starting at its cnt==0 negedge
  task automatic run_frame(input bit snd,
                           input logic [7:0] d,
                           input logic [1:0] m,
                           input logic [15:0] off1);
    for (int i = 0; i < 16; i++) begin
      if (i == 0 && snd) begin
        din_valid = 1'b1;
        din       = d;
        mode      = m;
      end else if (i == 1) begin
        din_valid = 1'b0;
      end
      enable = {~off1[i], 1'b1};
      v0[i]  = dout[0];
      v1[i]  = dout[1];
      fr[i]  = frame;
      rdy[i] = din_ready;
      @(negedge clk);
    end
  endtask

  // after releasing reset: ready delay, then distance to first frame
  task automatic release_and_align(input string tag);
    aresetn = 1'b1;
    n = 0;
    while (!din_ready && n < 5) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, {31'd0, din_ready}, 32'd1);
    n = 0;
    while (!frame && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cnt0"}, n, 32'd16);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn   = 1'b0;
    din       = '0;
    mode      = '0;
    enable    = 2'b11;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", {30'd0, dout}, 32'd0);
    check("rst_frame", {31'd0, frame}, 32'd0);
    check("rst_rdy", {31'd0, din_ready}, 32'd0);
    release_and_align("rel1");

    // ch0 PDM 4, ch1 PWM 5
    run_frame(1'b1, {4'd5, 4'd4}, 2'b10, 16'h0);
    check("p0_d0", v0, 32'h0000);
    check("p0_d1", v1, 32'h0000);
    check("p0_rdy", rdy, 32'h0001);
    check("p0_fr", fr, 32'h0001);
    run_frame(1'b0, 8'h0, 2'b00, 16'h0);
    check("p1_d0", v0, 32'h1110);
    check("p1_d1", v1, 32'h003E);
    check("p1_rdy", rdy, 32'hFFFF);
    check("p1_fr", fr, 32'h0001);
    // ch0 PWM 15, ch1 PWM 0
    run_frame(1'b1, {4'd0, 4'd15}, 2'b11, 16'h0);
    check("p2_d0", v0, 32'h1111);
    check("p2_d1", v1, 32'h003E);
    run_frame(1'b0, 8'h0, 2'b00, 16'h0);
    check("p3_d0", v0, 32'hFFFF);
    check("p3_d1", v1, 32'h0000);
    run_frame(1'b0, 8'h0, 2'b00, 16'h0);
    check("p4_d0", v0, 32'hFFFE);
    check("p4_d1", v1, 32'h0000);

    // valid held across two frames with changing data
    din_valid = 1'b1;
    din       = {4'd7, 4'd3};
    mode      = 2'b11;
    for (int i = 0; i < 16; i++) begin
      if (i == 1) din = {4'd12, 4'd9};
      v0[i]  = dout[0];
      v1[i]  = dout[1];
      rdy[i] = din_ready;
      @(negedge clk);
    end
    check("x_d0", v0, 32'hFFFE);
    check("x_d1", v1, 32'h0000);
    check("x_rdy", rdy, 32'h0001);
    for (int i = 0; i < 16; i++) begin
      if (i == 1) din_valid = 1'b0;
      v0[i]  = dout[0];
      v1[i]  = dout[1];
      rdy[i] = din_ready;
      @(negedge clk);
    end
    check("y_d0", v0, 32'h000E);
    check("y_d1", v1, 32'h00FE);
    check("y_rdy", rdy, 32'h0001);
    run_frame(1'b0, 8'h0, 2'b00, 16'h0);
    check("z_d0", v0, 32'h03FE);
    check("z_d1", v1, 32'h1FFE);
    check("z_rdy", rdy, 32'hFFFF);

    // ch0 PDM 8 / ch1 PWM 8, then swap to ch0 PWM 3 / ch1 PDM 3
    run_frame(1'b1, {4'd8, 4'd8}, 2'b10, 16'h0);
    check("w0_d0", v0, 32'h03FE);
    check("w0_d1", v1, 32'h1FFE);
    run_frame(1'b1, {4'd3, 4'd3}, 2'b01, 16'h0);
    check("w_d0", v0, 32'h5554);
    check("w_d1", v1, 32'h01FE);
    run_frame(1'b1, {4'd4, 4'd4}, 2'b00, 16'h0);
    check("v_d0", v0, 32'h000F);
    check("v_d1", v1, 32'h0840);

    // both PDM 4, then enable[1] dropped for 7 cycles
    run_frame(1'b0, 8'h0, 2'b00, 16'h0);
    check("u_d0", v0, 32'h1110);
    check("u_d1", v1, 32'h1111);
    run_frame(1'b0, 8'h0, 2'b00, 16'h01FC);
    check("s_d0", v0, 32'h1111);
    check("s_d1", v1, 32'h2001);
    run_frame(1'b0, 8'h0, 2'b00, 16'h0);
    check("r_d0", v0, 32'h1111);
    check("r_d1", v1, 32'h2222);

    // reset mid-frame with an update pending
    din_valid = 1'b1;
    din       = {4'd9, 4'd9};
    mode      = 2'b11;
    @(negedge clk);
    din_valid = 1'b0;
    check("q_pend", {31'd0, din_ready}, 32'd0);
    repeat (4) @(negedge clk);
    check("q_pre", {30'd0, dout}, 32'd2);
    aresetn = 1'b0;
    #1;
    check("q_dout", {30'd0, dout}, 32'd0);
    check("q_rdy", {31'd0, din_ready}, 32'd0);
    check("q_frame", {31'd0, frame}, 32'd0);
    repeat (2) @(negedge clk);
    release_and_align("rel2");
    run_frame(1'b0, 8'h0, 2'b00, 16'h0);
    check("a1_d0", v0, 32'h0000);
    check("a1_d1", v1, 32'h0000);
    check("a1_rdy", rdy, 32'hFFFF);
    run_frame(1'b0, 8'h0, 2'b00, 16'h0);
    check("a2_d0", v0, 32'h0000);
    check("a2_d1", v1, 32'h0000);
    check("a2_fr", fr, 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
